// File: rtl/alu_fwd_hazard_ctrl.sv
// ALU operand forwarding / load-use hazard controller with EX, MEM, WB shadow stages.
// Selects and ex_bubble register one clk after ID; pc/ifid hold is combinational; ext_stall freezes all state.
module alu_fwd_hazard_ctrl #(
    parameter int               REG_W    = 5,
    parameter logic [REG_W-1:0] ZERO_REG = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_alu_src,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             flush,
    input  logic             ext_stall,
    output logic             a_s,
    output logic             a_t,
    output logic             b_s,
    output logic             b_t,
    output logic             pc_hold,
    output logic             ifid_hold,
    output logic             ex_bubble
);

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             reg_write;
        logic             mem_read;
    } stage_t;

    localparam logic [1:0] SEL_RF    = 2'b00;
    localparam logic [1:0] SEL_EXMEM = 2'b01;
    localparam logic [1:0] SEL_MEMWB = 2'b10;
    localparam logic [1:0] SEL_IMM   = 2'b11;

    stage_t     ex_q, mem_q, wb_q, id_stage;
    logic [1:0] sel_a_q, sel_b_q, sel_a_d, sel_b_d;
    logic       ex_bubble_q;
    logic       ex_prod, mem_prod, hazard;
    logic       unused_wb;

    assign ex_prod  = ex_q.valid  && ex_q.reg_write  && (ex_q.rd  != ZERO_REG);
    assign mem_prod = mem_q.valid && mem_q.reg_write && (mem_q.rd != ZERO_REG);

    assign hazard = ex_prod && ex_q.mem_read && id_valid &&
                    ((id_use_rs && (ex_q.rd == id_rs)) ||
                     (id_use_rt && !id_alu_src && (ex_q.rd == id_rt)));

    assign pc_hold   = (hazard && !flush) || ext_stall;
    assign ifid_hold = (hazard && !flush) || ext_stall;

    assign id_stage = '{valid: id_valid, rd: id_rd, reg_write: id_reg_write, mem_read: id_mem_read};

    // EX producer is the youngest, so it is checked before MEM
    always_comb begin
        sel_a_d = SEL_RF;
        sel_b_d = SEL_RF;
        if (id_use_rs) begin
            if (ex_prod && (ex_q.rd == id_rs))
                sel_a_d = SEL_EXMEM;
            else if (mem_prod && (mem_q.rd == id_rs))
                sel_a_d = SEL_MEMWB;
        end
        if (id_alu_src) begin
            sel_b_d = SEL_IMM;
        end else if (id_use_rt) begin
            if (ex_prod && (ex_q.rd == id_rt))
                sel_b_d = SEL_EXMEM;
            else if (mem_prod && (mem_q.rd == id_rt))
                sel_b_d = SEL_MEMWB;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            sel_a_q     <= SEL_RF;
            sel_b_q     <= SEL_RF;
            ex_bubble_q <= 1'b0;
        end else if (!ext_stall) begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            if (flush) begin
                ex_q        <= '0;
                sel_a_q     <= SEL_RF;
                sel_b_q     <= SEL_RF;
                ex_bubble_q <= 1'b0;
            end else if (hazard) begin
                ex_q        <= '0;
                sel_a_q     <= SEL_RF;
                sel_b_q     <= SEL_RF;
                ex_bubble_q <= 1'b1;
            end else begin
                ex_q        <= id_stage;
                sel_a_q     <= sel_a_d;
                sel_b_q     <= sel_b_d;
                ex_bubble_q <= 1'b0;
            end
        end
    end

    // WB is shadowed but never forwarded: the register file writes before it is read
    assign unused_wb = ^wb_q;

    assign a_s       = sel_a_q[1];
    assign a_t       = sel_a_q[0];
    assign b_s       = sel_b_q[1];
    assign b_t       = sel_b_q[0];
    assign ex_bubble = ex_bubble_q;

endmodule

// File: tb/tb_alu_fwd_hazard_ctrl.sv
// Scoreboard bench: a history-queue model of issued instructions predicts holds and selects.
module tb_alu_fwd_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid, id_use_rs, id_use_rt, id_alu_src, id_reg_write, id_mem_read;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       flush, ext_stall;
    logic       a_s, a_t, b_s, b_t, pc_hold, ifid_hold, ex_bubble;

    alu_fwd_hazard_ctrl #(.REG_W(5), .ZERO_REG(5'd0)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_alu_src(id_alu_src),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .flush(flush), .ext_stall(ext_stall),
        .a_s(a_s), .a_t(a_t), .b_s(b_s), .b_t(b_t),
        .pc_hold(pc_hold), .ifid_hold(ifid_hold), .ex_bubble(ex_bubble)
    );

    always #5 clk = ~clk;

    typedef struct { int dst; bit ld; } rec_t;
    typedef struct { int sa; int sb; int bub; } reg_exp_t;

    rec_t     hist[$];
    int       hold_q[$];
    reg_exp_t reg_q[$];
    reg_exp_t cur;
    int       n_checks = 0;
    int       n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        rec_t none;
        none.dst = -1;
        none.ld  = 1'b0;
        hist.delete();
        repeat (3) hist.push_back(none);
        cur = '{sa: 0, sb: 0, bub: 0};
    endfunction

    // hist[0] is the instruction now in EX, hist[1] the one in MEM
    function automatic int fwd(input int src);
        if (hist[0].dst == src) return 1;
        if (hist[1].dst == src) return 2;
        return 0;
    endfunction

    task automatic drive(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                         input bit alu, input int rd, input bit rw, input bit mr,
                         input bit fl, input bit st);
        bit   hz;
        rec_t r;
        id_valid = v; id_rs = 5'(rs); id_rt = 5'(rt); id_use_rs = urs; id_use_rt = urt;
        id_alu_src = alu; id_rd = 5'(rd); id_reg_write = rw; id_mem_read = mr;
        flush = fl; ext_stall = st;
        hz = v && hist[0].ld && hist[0].dst >= 0 &&
             ((urs && hist[0].dst == rs) || (urt && !alu && hist[0].dst == rt));
        hold_q.push_back(((hz && !fl) || st) ? 1 : 0);
        if (!st) begin
            r.dst = -1;
            r.ld  = 1'b0;
            if (fl) begin
                cur = '{sa: 0, sb: 0, bub: 0};
            end else if (hz) begin
                cur = '{sa: 0, sb: 0, bub: 1};
            end else begin
                cur.sa  = urs ? fwd(rs) : 0;
                cur.sb  = alu ? 3 : (urt ? fwd(rt) : 0);
                cur.bub = 0;
                if (v && rw && rd != 0) begin
                    r.dst = rd;
                    r.ld  = mr;
                end
            end
            hist.push_front(r);
            void'(hist.pop_back());
        end
        reg_q.push_back(cur);
    endtask

    task automatic op(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                      input bit alu, input int rd, input bit rw, input bit mr,
                      input bit fl, input bit st);
        drive(v, rs, rt, urs, urt, alu, rd, rw, mr, fl, st);
        @(negedge clk);
    endtask

    // Monitor: holds are checked against the inputs just driven, registered outputs against the previous edge
    initial begin
        int       h;
        reg_exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (hold_q.size() > 0) begin
                h = hold_q.pop_front();
                check("pc_hold", int'(pc_hold), h);
                check("ifid_hold", int'(ifid_hold), h);
                if (reg_q.size() == 0) begin
                    check("reg_q_underflow", 1, 0);
                end else begin
                    e = reg_q.pop_front();
                    check("a_sel", int'({a_s, a_t}), e.sa);
                    check("b_sel", int'({b_s, b_t}), e.sb);
                    check("ex_bubble", int'(ex_bubble), e.bub);
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        id_valid = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0; id_alu_src = 0;
        id_rd = 0; id_reg_write = 0; id_mem_read = 0; flush = 0; ext_stall = 0;
        model_reset();
        reg_q.push_back(cur);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // back-to-back: add r3, then sub rs=3 rt=4
        op(1, 1, 2, 1, 1, 0, 3, 1, 0, 0, 0);
        op(1, 3, 4, 1, 1, 0, 9, 1, 0, 0, 0);
        // distance two: rd=5, independent, consumer rt=5
        op(1, 1, 2, 1, 1, 0, 5, 1, 0, 0, 0);
        op(1, 1, 2, 1, 1, 0, 6, 1, 0, 0, 0);
        op(1, 8, 5, 1, 1, 0, 10, 1, 0, 0, 0);
        // load-use: lw r7 then add rs=7 presented until it issues
        op(1, 1, 0, 1, 0, 1, 7, 1, 1, 0, 0);
        op(1, 7, 2, 1, 1, 0, 11, 1, 0, 0, 0);
        op(1, 7, 2, 1, 1, 0, 11, 1, 0, 0, 0);
        // zero register, then immediate operand with matching rt
        op(1, 1, 2, 1, 1, 0, 0, 1, 0, 0, 0);
        op(1, 0, 0, 1, 1, 0, 12, 1, 0, 0, 0);
        op(1, 1, 2, 1, 1, 0, 9, 1, 0, 0, 0);
        op(1, 4, 9, 1, 1, 1, 13, 1, 0, 0, 0);
        // flush together with a load-use hazard
        op(1, 1, 0, 1, 0, 1, 7, 1, 1, 0, 0);
        op(1, 7, 7, 1, 1, 0, 14, 1, 0, 1, 0);
        op(1, 7, 1, 1, 1, 0, 15, 1, 0, 0, 0);
        // ext_stall for three cycles around a forwarding consumer
        op(1, 1, 3, 1, 1, 0, 2, 1, 0, 0, 0);
        op(1, 2, 2, 1, 1, 0, 16, 1, 0, 0, 1);
        op(1, 2, 2, 1, 1, 0, 16, 1, 0, 0, 1);
        op(1, 2, 2, 1, 1, 0, 16, 1, 0, 0, 1);
        op(1, 2, 2, 1, 1, 0, 16, 1, 0, 0, 0);

        // async reset in the middle of a load-use stall, with a forwarding select live
        op(1, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0);
        op(1, 1, 0, 1, 0, 1, 7, 1, 1, 0, 0);
        drive(1, 7, 2, 1, 1, 0, 17, 1, 0, 0, 0);
        #4;
        reset = 1'b1;
        #1;
        check("rst_a_sel", int'({a_s, a_t}), 0);
        check("rst_b_sel", int'({b_s, b_t}), 0);
        check("rst_ex_bubble", int'(ex_bubble), 0);
        check("rst_pc_hold", int'(pc_hold), 0);
        check("rst_ifid_hold", int'(ifid_hold), 0);
        model_reset();
        reg_q.delete();
        reg_q.push_back(cur);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            op($urandom_range(0, 9) != 0,
               $urandom_range(0, 7), $urandom_range(0, 7),
               $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
               $urandom_range(0, 3) == 0,
               $urandom_range(0, 7), $urandom_range(0, 4) != 0,
               $urandom_range(0, 2) == 0,
               $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
        end
        #3;
        if (hold_q.size() != 0) check("hold_q_drain", hold_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_fwd_hazard_ctrl.md
Name: alu_fwd_hazard_ctrl

Overview:
- Forwarding and hazard controller for the MIPS pipeline ALU operand muxes.
- Tracks destination register, write-enable and load flag of the instructions in EX, MEM and WB in its own shadow pipeline.
- Produces registered {s,t} selects for the two four-path operand muxes and the load-use stall/bubble controls.
- Sits beside the ID/EX register; selects are valid for the instruction currently in EX.

Parameters:
- REG_W, 5, register-index width.
- ZERO_REG, 0, index never forwarded (hardwired zero).

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- id_valid  input  1  ID holds a real instruction.
- id_rs  input  REG_W  source register A.
- id_rt  input  REG_W  source register B.
- id_use_rs  input  1  instruction reads rs.
- id_use_rt  input  1  instruction reads rt.
- id_alu_src  input  1  operand B is immediate.
- id_rd  input  REG_W  destination register.
- id_reg_write  input  1  instruction writes rd.
- id_mem_read  input  1  instruction is a load.
- flush  input  1  branch taken: squash the ID instruction.
- ext_stall  input  1  memory wait: freeze all stages.
- a_s, a_t  output  1 each  operand-A mux select.
- b_s, b_t  output  1 each  operand-B mux select.
- pc_hold  output  1  hold PC.
- ifid_hold  output  1  hold IF/ID register.
- ex_bubble  output  1  EX holds an injected bubble.

Behaviour:
- Mux encoding {s,t}:
  - 00 = register file (input a).
  - 01 = EX/MEM ALU result (input b).
  - 10 = MEM/WB writeback (input c).
  - 11 = immediate (input d); operand B only.
- Shadow stages ex_, mem_, wb_ each hold {valid, rd, reg_write, mem_read}.
- Producer qualifies only when valid & reg_write & rd != ZERO_REG.
- Load-use hazard (combinational): ex_ producer is a load & id_valid & ((id_use_rs & ex_.rd==id_rs) | (id_use_rt & !id_alu_src & ex_.rd==id_rt)).
  - pc_hold = ifid_hold = hazard & !flush, or ext_stall.
- Per rising clk, priority highest first:
  1. ext_stall: all shadow stages and selects hold; ex_bubble holds.
  2. Otherwise shift wb_<=mem_ and mem_<=ex_.
  3. ex_ loads as follows:
     - flush: bubble (valid=0), selects 00/00, ex_bubble=0.
     - Hazard: bubble, selects 00/00, ex_bubble=1.
     - Else: ex_<=ID fields with valid=id_valid, ex_bubble=0, selects computed per the rules below.
- Select computation, per used operand, from pre-edge state:
  - A match with ex_ (producer moving to MEM) gives 01.
  - Else a match with mem_ gives 10.
  - Else 00.
  - The ex_ match wins over mem_ (youngest producer).
  - A WB-stage producer is not forwarded; the register file is write-before-read.
  - Operand B with id_alu_src=1 always gives 11.
  - An unused operand gives 00.
- Load-use: one bubble only.
  - Next cycle the load is in mem_ and the consumer gets 10.
  - The stalled instruction is re-evaluated with unchanged ID inputs.
- Reset, asynchronous: all shadow valid=0; all selects 00; ex_bubble=0.
  - pc_hold and ifid_hold then evaluate to 0 unless ext_stall is asserted.
  - Reset mid-stall cancels the stall immediately.
- Simultaneous flush and hazard: flush wins; no hold; squashed entry is not a bubble-stall.
- Latency: selects appear one clk after ID presentation, aligned with the EX-stage operands.

Test Plan:
- Back-to-back dependency:
  - Stimulus: add r3 (rd=3, reg_write) then sub using rs=3.
  - Response: after the 2nd edge a_s,a_t=0,1 and b selects 00.
- Distance-2 dependency:
  - Stimulus: producer rd=5, one independent instruction, then consumer rt=5 with alu_src=0.
  - Response: b_s,b_t=1,0.
- Load-use:
  - Stimulus: lw rd=7 (mem_read) then add rs=7.
  - Response: pc_hold=ifid_hold=1 for exactly one cycle; ex_bubble=1 for one cycle; the following cycle a selects = 10.
- Zero register and immediate:
  - Stimulus: producer rd=0 followed by consumer rs=0.
  - Response: a selects stay 00.
  - Stimulus: consumer with id_alu_src=1.
  - Response: b selects = 11 regardless of rt match.
- Flush and ext_stall:
  - Stimulus: flush asserted together with a load-use hazard.
  - Response: no hold; ex_ invalid; ex_bubble=0.
  - Stimulus: ext_stall high for 3 cycles.
  - Response: selects and stages are frozen, and resume unchanged.
- Async reset:
  - Stimulus: reset asserted mid-stall between clock edges.
  - Response: immediately all selects 00, ex_bubble=0, pc_hold=0.
